gf180mcu_req_arb2: RTL and testbench

//  Two-requester round-robin arbiter with a registered output stage. It forms the return/grant side of an OR2 request merge.
//  Z is the plain OR of the two valids. The block also decides which requester is served, returns a per-input READY
//  and forwards that requester's payload through a one-entry output register.

---
 rtl/gf180mcu_req_arb2.sv | 102 ++++++++++
 tb/tb_gf180mcu_req_arb2.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_req_arb2.sv
// Two-requester round-robin arbiter feeding a one-entry registered output stage.
// Optional macro GF180MCU_REQ_ARB2_LOCK_EN adds A1_LOCK/A2_LOCK burst locking.
module gf180mcu_req_arb2 #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          A1_VALID,
  input  logic [DW-1:0] A1_DATA,
  output logic          A1_READY,
  input  logic          A2_VALID,
  input  logic [DW-1:0] A2_DATA,
  output logic          A2_READY,
`ifdef GF180MCU_REQ_ARB2_LOCK_EN
  input  logic          A1_LOCK,
  input  logic          A2_LOCK,
`endif
  output logic          Z,
  output logic          Z_VALID,
  output logic [DW-1:0] Z_DATA,
  output logic          Z_SRC,
  input  logic          Z_READY
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state;
  logic          last;
  logic          free;
  logic          grant1;
  logic          grant2;
  logic          accept1;
  logic          accept2;
  logic          acc_any;
  logic          acc_src;
  logic [DW-1:0] acc_data;
  logic          next_last;

  assign Z = A1_VALID | A2_VALID;

  // The slot can take a new payload when empty or when it drains this cycle.
  assign free = (state == EMPTY) | Z_READY;

  // last holds the index of the most recently served requester; the other wins ties.
  assign grant1 = A1_VALID & (~A2_VALID | last);
  assign grant2 = A2_VALID & (~A1_VALID | ~last);

  assign A1_READY = grant1 & free & ~RST;
  assign A2_READY = grant2 & free & ~RST;

  assign accept1  = A1_VALID & A1_READY;
  assign accept2  = A2_VALID & A2_READY;
  assign acc_any  = accept1 | accept2;
  assign acc_src  = accept2;
  assign acc_data = accept2 ? A2_DATA : A1_DATA;

`ifdef GF180MCU_REQ_ARB2_LOCK_EN
  // A locked accept points last at the other source so the same source keeps priority.
  logic acc_lock;
  assign acc_lock  = accept2 ? A2_LOCK : A1_LOCK;
  assign next_last = acc_lock ? ~acc_src : acc_src;
`else
  assign next_last = acc_src;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= EMPTY;
      Z_VALID <= 1'b0;
      Z_DATA  <= '0;
      Z_SRC   <= 1'b0;
      last    <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (acc_any) begin
            state   <= FULL;
            Z_VALID <= 1'b1;
            Z_DATA  <= acc_data;
            Z_SRC   <= acc_src;
            last    <= next_last;
          end
        end
        FULL: begin
          if (acc_any) begin
            Z_DATA <= acc_data;
            Z_SRC  <= acc_src;
            last   <= next_last;
          end else if (Z_READY) begin
            state   <= EMPTY;
            Z_VALID <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          Z_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf180mcu_req_arb2.sv
// Directed and randomized self-checking bench for gf180mcu_req_arb2.
// Define GF180MCU_REQ_ARB2_LOCK_EN to also exercise burst locking.
module tb_gf180mcu_req_arb2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       A1_VALID, A2_VALID;
  logic [7:0] A1_DATA, A2_DATA;
  logic       A1_READY, A2_READY;
  logic       Z, Z_VALID, Z_SRC, Z_READY;
  logic [7:0] Z_DATA;
`ifdef GF180MCU_REQ_ARB2_LOCK_EN
  logic       A1_LOCK, A2_LOCK;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  gf180mcu_req_arb2 #(.DW(8)) dut (
    .CLK(CLK), .RST(RST),
    .A1_VALID(A1_VALID), .A1_DATA(A1_DATA), .A1_READY(A1_READY),
    .A2_VALID(A2_VALID), .A2_DATA(A2_DATA), .A2_READY(A2_READY),
`ifdef GF180MCU_REQ_ARB2_LOCK_EN
    .A1_LOCK(A1_LOCK), .A2_LOCK(A2_LOCK),
`endif
    .Z(Z), .Z_VALID(Z_VALID), .Z_DATA(Z_DATA), .Z_SRC(Z_SRC), .Z_READY(Z_READY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [8:0] sb[$];
  logic [8:0] exp_entry;
  logic       p1, p2, a1, a2;
  logic [7:0] d1, d2;
  int         wait1, wait2;

  initial begin
    RST = 1'b1;
    A1_VALID = 1'b1; A1_DATA = 8'h11;
    A2_VALID = 1'b1; A2_DATA = 8'h22;
    Z_READY = 1'b1;
`ifdef GF180MCU_REQ_ARB2_LOCK_EN
    A1_LOCK = 1'b0; A2_LOCK = 1'b0;
`endif

    // reset with both requesting, then strict alternation starting at A1
    @(negedge CLK); @(negedge CLK); #1;
    check("rst_a1_ready", A1_READY, 0);
    check("rst_a2_ready", A2_READY, 0);
    check("rst_z", Z, 1);
    check("rst_z_valid", Z_VALID, 0);
    check("rst_z_data", Z_DATA, 0);
    @(negedge CLK); RST = 1'b0; #1;
    check("first_a1_ready", A1_READY, 1);
    check("first_a2_ready", A2_READY, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      check("rr_z_valid", Z_VALID, 1);
      check("rr_z_src", Z_SRC, i % 2);
      check("rr_z_data", Z_DATA, (i % 2) ? 8'h22 : 8'h11);
    end

    // A2 alone
    A1_VALID = 1'b0; A2_VALID = 1'b0;
    @(negedge CLK); #1;
    check("idle_z", Z, 0);
    A2_VALID = 1'b1; A2_DATA = 8'h5A; #1;
    check("a2_only_ready", A2_READY, 1);
    check("a2_only_a1_ready", A1_READY, 0);
    @(negedge CLK); A2_VALID = 1'b0; #1;
    check("a2_only_z_valid", Z_VALID, 1);
    check("a2_only_z_data", Z_DATA, 8'h5A);
    check("a2_only_z_src", Z_SRC, 1);

    // backpressure while FULL, then simultaneous drain and accept
    Z_READY = 1'b0;
    A1_VALID = 1'b1; A1_DATA = 8'h33;
    A2_VALID = 1'b1; A2_DATA = 8'h44; #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_a1_ready", A1_READY, 0);
      check("bp_a2_ready", A2_READY, 0);
      @(negedge CLK); #1;
      check("bp_z_data", Z_DATA, 8'h5A);
      check("bp_z_valid", Z_VALID, 1);
    end
    Z_READY = 1'b1; #1;
    check("bp_rel_a1_ready", A1_READY, 1);
    check("bp_rel_a2_ready", A2_READY, 0);
    @(negedge CLK);
    A2_VALID = 1'b0;
    A1_DATA = 8'hC3; #1;
    check("bp_rel_z_data", Z_DATA, 8'h33);
    check("bp_rel_z_src", Z_SRC, 0);

    // async reset while FULL with C3; pointer must come back to A1
    @(negedge CLK);
    Z_READY = 1'b0; A1_VALID = 1'b0; #1;
    check("pre_rst_z_data", Z_DATA, 8'hC3);
    check("pre_rst_z_valid", Z_VALID, 1);
    @(posedge CLK); #2 RST = 1'b1; #1;
    check("arst_z_valid", Z_VALID, 0);
    check("arst_z_data", Z_DATA, 0);
    A1_VALID = 1'b1; A2_VALID = 1'b1; A1_DATA = 8'h77; A2_DATA = 8'h88; #1;
    check("arst_a1_ready", A1_READY, 0);
    @(negedge CLK); RST = 1'b0; #1;
    check("post_rst_a1_ready", A1_READY, 1);
    check("post_rst_a2_ready", A2_READY, 0);
    @(negedge CLK);
    A1_VALID = 1'b0; A2_VALID = 1'b0; Z_READY = 1'b1; #1;
    check("post_rst_z_data", Z_DATA, 8'h77);
    check("post_rst_z_src", Z_SRC, 0);

`ifdef GF180MCU_REQ_ARB2_LOCK_EN
    // A2 burst of three beats held contiguous against a waiting A1
    @(negedge CLK);
    A1_VALID = 1'b1; A1_DATA = 8'h99; A1_LOCK = 1'b0;
    A2_VALID = 1'b1;
    for (int b = 0; b < 3; b++) begin
      A2_LOCK = (b < 2);
      A2_DATA = 8'hA0 + 8'(b); #1;
      check("lock_a2_ready", A2_READY, 1);
      @(negedge CLK); #1;
      check("lock_z_src", Z_SRC, 1);
      check("lock_z_data", Z_DATA, 8'hA0 + 8'(b));
    end
    A2_LOCK = 1'b0; A2_DATA = 8'hA3; #1;
    check("unlock_a1_ready", A1_READY, 1);
    @(negedge CLK); #1;
    check("unlock_z_src", Z_SRC, 0);
    check("unlock_z_data", Z_DATA, 8'h99);
    A1_VALID = 1'b0; A2_VALID = 1'b0;
`endif

    // randomized traffic against a scoreboard
    @(negedge CLK); @(negedge CLK);
    p1 = 1'b0; p2 = 1'b0; d1 = '0; d2 = '0; wait1 = 0; wait2 = 0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      @(negedge CLK);
      if (cyc < 10000) begin
        if (!p1 && $urandom_range(0, 3) != 0) begin p1 = 1'b1; d1 = 8'($urandom); end
        if (!p2 && $urandom_range(0, 3) != 0) begin p2 = 1'b1; d2 = 8'($urandom); end
        Z_READY = ($urandom_range(0, 3) != 0);
      end else begin
        Z_READY = 1'b1;
      end
      A1_VALID = p1; A1_DATA = d1;
      A2_VALID = p2; A2_DATA = d2;
      #1;
      check("one_ready", A1_READY & A2_READY, 0);
      check("ready_without_valid", (A1_READY & ~A1_VALID) | (A2_READY & ~A2_VALID), 0);
      if (Z_VALID && Z_READY) begin
        check("drain_with_empty_sb", sb.size() == 0, 0);
        if (sb.size() != 0) begin
          exp_entry = sb.pop_front();
          check("rand_out", {Z_SRC, Z_DATA}, exp_entry);
        end
      end
      a1 = A1_VALID & A1_READY;
      a2 = A2_VALID & A2_READY;
      if (a1) begin
        sb.push_back({1'b0, d1});
        check("a1_max_wait", wait1 <= 1, 1);
        wait1 = 0; p1 = 1'b0;
      end else if (p1 && a2) begin
        wait1++;
      end
      if (a2) begin
        sb.push_back({1'b1, d2});
        check("a2_max_wait", wait2 <= 1, 1);
        wait2 = 0; p2 = 1'b0;
      end else if (p2 && a1) begin
        wait2++;
      end
    end
    A1_VALID = 1'b0; A2_VALID = 1'b0;
    @(negedge CLK); #1;
    check("final_pending_a1", p1, 0);
    check("final_pending_a2", p2, 0);
    check("final_sb_size", sb.size(), 0);
    check("final_z_valid", Z_VALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
